// File: rtl/cpu8_pkg.sv
// Shared widths, types and fetch-state encoding for the cpu8 front end.
package cpu8_pkg;

    localparam int PC_W   = 15;
    localparam int DATA_W = 8;
    localparam int PAGE_W = 8;
    localparam int OFS_W  = 7;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        byte_t data;
        pc_t   pc;
    } fifo_entry_t;

    // Sequential fetch address; wraps 0x7FFF -> 0x0000 by width.
    function automatic pc_t pc_next(input pc_t pc);
        return pc + 15'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register instruction buffer; slot 0 is always the head so outputs come straight from flops.
module fetch_fifo
    import cpu8_pkg::*;
#(
    parameter int DEPTH = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAST  = DEPTH - 1;

    fifo_entry_t      ent_r [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] wr_idx_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign head  = ent_r[0];

    // A push on a full buffer is accepted only when the head leaves in the same cycle.
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        if (pop_ok_s) begin
            wr_idx_s = count_r - CNT_W'(1);
        end else begin
            wr_idx_s = count_r;
        end
    end

    // Entry storage and occupancy; clear wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
        end else if (clear) begin
            count_r <= CNT_W'(0);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok_s && (wr_idx_s == CNT_W'(i))) begin
                    ent_r[i] <= push_entry;
                end else if (pop_ok_s && (i < LAST)) begin
                    ent_r[i] <= ent_r[(i < LAST) ? i + 1 : i];
                end
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding byte read feeding a small decode buffer.
// Defining FETCH_PREFETCH_EN deepens the buffer to two bytes so fetch overlaps a stalled decoder.
module fetch_unit
    import cpu8_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ins_data,
    output logic [PC_W-1:0]   ins_pc,
    input  logic              ins_ready
);

`ifdef FETCH_PREFETCH_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;
    pc_t          fetch_pc_r;
    pc_t          fetch_pc_nxt_s;
    logic         mem_req_r;
    logic         mem_req_nxt_s;
    pc_t          mem_addr_r;
    pc_t          mem_addr_nxt_s;

    logic         ack_s;
    logic         pop_s;
    logic         push_s;
    logic         room_s;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    fifo_entry_t  head_s;
    fifo_entry_t  push_entry_s;

    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign ins_valid = !fifo_empty_s;
    assign ins_data  = head_s.data;
    assign ins_pc    = head_s.pc;

    // Handshake qualifiers; an ack with no request outstanding is ignored.
    always_comb begin
        ack_s             = mem_ack && mem_req_r;
        pop_s             = ins_valid && ins_ready;
        push_s            = ack_s && (state_r == ST_WAIT) && !redirect;
        room_s            = !fifo_full_s || pop_s;
        push_entry_s.data = mem_data;
        push_entry_s.pc   = mem_addr_r;
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RST_N),
        .clear      (redirect),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    // Next-state and request decode.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        mem_req_nxt_s  = mem_req_r;
        mem_addr_nxt_s = mem_addr_r;
        case (state_r)
            ST_RUN: begin
                // A redirect only reloads the PC; the request goes out next cycle.
                if (redirect) begin
                    fetch_pc_nxt_s = redirect_pc;
                end else if (room_s) begin
                    mem_req_nxt_s  = 1'b1;
                    mem_addr_nxt_s = fetch_pc_r;
                    state_nxt_s    = ST_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (ack_s) begin
                    mem_req_nxt_s = 1'b0;
                    state_nxt_s   = ST_RUN;
                    if (redirect) begin
                        fetch_pc_nxt_s = redirect_pc;
                    end else begin
                        fetch_pc_nxt_s = pc_next(fetch_pc_r);
                    end
                end else if (redirect) begin
                    fetch_pc_nxt_s = redirect_pc;
                    state_nxt_s    = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                if (redirect) begin
                    fetch_pc_nxt_s = redirect_pc;
                end else begin
                    fetch_pc_nxt_s = fetch_pc_r;
                end
                if (ack_s) begin
                    mem_req_nxt_s = 1'b0;
                    state_nxt_s   = ST_RUN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s   = ST_RUN;
                mem_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State, PC and request registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_RUN;
            fetch_pc_r <= 15'h0000;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 15'h0000;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            mem_req_r  <= mem_req_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; expectations adapt to FETCH_PREFETCH_EN.
module tb_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic        redirect;
    logic [14:0] redirect_pc;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        ins_valid;
    logic [7:0]  ins_data;
    logic [14:0] ins_pc;
    logic        ins_ready;

`ifdef FETCH_PREFETCH_EN
    localparam int EXP_DEPTH = 2;
`else
    localparam int EXP_DEPTH = 1;
`endif

    typedef struct {
        logic        redir;
        logic [14:0] rpc;
        logic        ack;
        logic [7:0]  dat;
        logic        rdy;
        logic        e_req;
        logic [14:0] e_addr;
        logic        e_valid;
        logic [7:0]  e_data;
        logic [14:0] e_pc;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_err    = 0;

    fetch_unit dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [14:0] rpc, input logic a, input logic [7:0] d,
                       input logic rdy, input logic er, input logic [14:0] ea, input logic ev,
                       input logic [7:0] ed, input logic [14:0] ep);
        vec_t v;
        v.redir = r;  v.rpc = rpc; v.ack = a; v.dat = d; v.rdy = rdy;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_data = ed; v.e_pc = ep;
        vq.push_back(v);
    endtask

    initial begin
        int acks;
        int waited;

        //   redir rpc       ack dat    rdy   req  addr      valid data   pc
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b0, 8'h00, 15'h0000); // 0
        add(1'b0, 15'h0000, 1'b1, 8'h10, 1'b1, 1'b1, 15'h0000, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h10, 15'h0000);
        add(1'b0, 15'h0000, 1'b1, 8'h11, 1'b1, 1'b1, 15'h0001, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h11, 15'h0001);
        add(1'b0, 15'h0000, 1'b1, 8'h12, 1'b1, 1'b1, 15'h0002, 1'b0, 8'h00, 15'h0000); // 5
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h12, 15'h0002);
        add(1'b1, 15'h1280, 1'b0, 8'h00, 1'b1, 1'b1, 15'h0003, 1'b0, 8'h00, 15'h0000); // redirect in WAIT
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 15'h0003, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b1, 8'hAA, 1'b1, 1'b1, 15'h0003, 1'b0, 8'h00, 15'h0000); // flushed ack
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b0, 8'h00, 15'h0000); // 10
        add(1'b0, 15'h0000, 1'b1, 8'h20, 1'b1, 1'b1, 15'h1280, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h20, 15'h1280);
        add(1'b1, 15'h0100, 1'b1, 8'h55, 1'b1, 1'b1, 15'h1281, 1'b0, 8'h00, 15'h0000); // redirect + ack
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b1, 8'h30, 1'b1, 1'b1, 15'h0100, 1'b0, 8'h00, 15'h0000); // 15
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h30, 15'h0100);
        add(1'b0, 15'h0000, 1'b1, 8'h31, 1'b0, 1'b1, 15'h0101, 1'b0, 8'h00, 15'h0000);
        add(1'b1, 15'h0200, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h31, 15'h0101); // redirect + pop
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b1, 8'h40, 1'b1, 1'b1, 15'h0200, 1'b0, 8'h00, 15'h0000); // 20
        add(1'b1, 15'h7FFF, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h40, 15'h0200);
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b1, 8'h50, 1'b1, 1'b1, 15'h7FFF, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h50, 15'h7FFF);
        add(1'b0, 15'h0000, 1'b1, 8'h51, 1'b1, 1'b1, 15'h0000, 1'b0, 8'h00, 15'h0000); // 25 wrapped
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h51, 15'h0000);
        add(1'b1, 15'h0300, 1'b0, 8'h00, 1'b1, 1'b1, 15'h0001, 1'b0, 8'h00, 15'h0000); // -> FLUSH
        add(1'b1, 15'h0400, 1'b0, 8'h00, 1'b1, 1'b1, 15'h0001, 1'b0, 8'h00, 15'h0000); // redirect in FLUSH
        add(1'b0, 15'h0000, 1'b1, 8'hBB, 1'b1, 1'b1, 15'h0001, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b0, 8'h00, 15'h0000); // 30
        add(1'b0, 15'h0000, 1'b1, 8'h60, 1'b1, 1'b1, 15'h0400, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h60, 15'h0400);
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 15'h0401, 1'b0, 8'h00, 15'h0000); // request held
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 15'h0401, 1'b0, 8'h00, 15'h0000);
        add(1'b0, 15'h0000, 1'b1, 8'h61, 1'b1, 1'b1, 15'h0401, 1'b0, 8'h00, 15'h0000); // 35
        add(1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h61, 15'h0401);

        // Reset values
        RST_N = 1'b0; redirect = 1'b0; redirect_pc = 15'h0000;
        mem_ack = 1'b0; mem_data = 8'h00; ins_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst ins_data", {24'd0, ins_data}, 32'd0);
        chk("rst ins_pc", {17'd0, ins_pc}, 32'd0);
        RST_N = 1'b1;

        // Cycle-accurate vector table
        for (int i = 0; i < vq.size(); i++) begin
            redirect = vq[i].redir; redirect_pc = vq[i].rpc;
            mem_ack = vq[i].ack; mem_data = vq[i].dat; ins_ready = vq[i].rdy;
            @(negedge CLK);
            chk($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, vq[i].e_req});
            if (vq[i].e_req)
                chk($sformatf("v%0d mem_addr", i), {17'd0, mem_addr}, {17'd0, vq[i].e_addr});
            chk($sformatf("v%0d ins_valid", i), {31'd0, ins_valid}, {31'd0, vq[i].e_valid});
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d ins_data", i), {24'd0, ins_data}, {24'd0, vq[i].e_data});
                chk($sformatf("v%0d ins_pc", i), {17'd0, ins_pc}, {17'd0, vq[i].e_pc});
            end
            @(posedge CLK);
            #1;
        end

        // Decoder stalled for 12 cycles: buffer fills to its depth and fetch stops
        redirect = 1'b0; ins_ready = 1'b0; acks = 0;
        for (int c = 0; c < 12; c++) begin
            mem_ack = mem_req;
            mem_data = 8'h70 + 8'(acks);
            if (mem_req) acks++;
            @(posedge CLK);
            #1;
        end
        mem_ack = 1'b0;
        chk("stall acks", acks, EXP_DEPTH);
        chk("stall mem_req", {31'd0, mem_req}, 32'd0);
        chk("stall ins_valid", {31'd0, ins_valid}, 32'd1);
        chk("stall ins_pc", {17'd0, ins_pc}, 32'h0402);
        chk("stall ins_data", {24'd0, ins_data}, 32'h70);

        // Single pop after the stall
        ins_ready = 1'b1;
        @(posedge CLK);
        #1;
        ins_ready = 1'b0;
        chk("pop mem_req", {31'd0, mem_req}, 32'd1);
        if (EXP_DEPTH == 2) begin
            chk("pop ins_valid", {31'd0, ins_valid}, 32'd1);
            chk("pop ins_pc", {17'd0, ins_pc}, 32'h0403);
            chk("pop ins_data", {24'd0, ins_data}, 32'h71);
            chk("pop mem_addr", {17'd0, mem_addr}, 32'h0404);
        end else begin
            chk("pop ins_valid", {31'd0, ins_valid}, 32'd0);
            chk("pop mem_addr", {17'd0, mem_addr}, 32'h0403);
        end

        // Asynchronous reset while a request is outstanding
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("arst ins_data", {24'd0, ins_data}, 32'd0);
        chk("arst ins_pc", {17'd0, ins_pc}, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rel mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge CLK);
        #1;
        waited = 0;
        while (!mem_req && waited < 8) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        chk("restart req seen", {31'd0, mem_req}, 32'd1);
        chk("restart latency", waited, 0);
        chk("restart mem_addr", {17'd0, mem_addr}, 32'h0000);
        mem_ack = 1'b1; mem_data = 8'h90; ins_ready = 1'b1;
        @(posedge CLK);
        #1;
        mem_ack = 1'b0;
        chk("restart ins_valid", {31'd0, ins_valid}, 32'd1);
        chk("restart ins_pc", {17'd0, ins_pc}, 32'h0000);
        chk("restart ins_data", {24'd0, ins_data}, 32'h90);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
